// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and encodings for the F/D/E/W pipeline sequencer.
// The update codes are the values driven to the fdreg, dereg and ewreg pipeline registers.
package pipe_pkg;

  typedef logic [1:0] upd_t;

  localparam upd_t UPD_HOLD  = 2'b00;
  localparam upd_t UPD_ADV   = 2'b01;
  localparam upd_t UPD_FLUSH = 2'b10;

  // Destination register-file encoding of the E instruction; 1x selects the FP file.
  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_INT  = 2'b01;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    WAIT = 2'b01,
    HALT = 2'b10
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundles the hazard inputs and update-code outputs of pipeline_ctrl.
// The master modport is the pipeline side; the slave modport is the controller.
interface pipeline_ctrl_if #(
  parameter int WAIT_W = 5,
  parameter int RSEL_W = 6
);
  import pipe_pkg::*;

  logic [RSEL_W-1:0] d_rs;
  logic [RSEL_W-1:0] d_rt;
  logic              d_use_s;
  logic              d_use_t;
  logic [1:0]        de_rw;
  logic [4:0]        de_rd;
  logic              de_is_load;
  logic [WAIT_W-1:0] de_wait_time;
  logic              e_redirect;
  logic              de_stop;
  logic              resume;

  upd_t              fd_update;
  upd_t              de_update;
  upd_t              ew_update;
  logic              pc_en;
  logic              halted;

  // Debug view of the sequencer state so checkers can bind to it.
  ctrl_state_t       dbg_state;
  logic [WAIT_W-1:0] dbg_cnt;

  modport master (
    output d_rs, d_rt, d_use_s, d_use_t, de_rw, de_rd, de_is_load,
           de_wait_time, e_redirect, de_stop, resume,
    input  fd_update, de_update, ew_update, pc_en, halted, dbg_state, dbg_cnt
  );

  modport slave (
    input  d_rs, d_rt, d_use_s, d_use_t, de_rw, de_rd, de_is_load,
           de_wait_time, e_redirect, de_stop, resume,
    output fd_update, de_update, ew_update, pc_en, halted, dbg_state, dbg_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Detects a load in E whose destination is read by the instruction in D.
// Register 0 is compared like any other index, matching the forwarding compare.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int RSEL_W = 6
) (
  input  logic [RSEL_W-1:0] d_rs,
  input  logic [RSEL_W-1:0] d_rt,
  input  logic              d_use_s,
  input  logic              d_use_t,
  input  logic [1:0]        de_rw,
  input  logic [4:0]        de_rd,
  input  logic              de_is_load,
  output logic              stall_lu
);

  logic hit_s;
  logic hit_t;

  // Source MSB picks the FP file; it must agree with the destination file bit.
  assign hit_s = d_use_s && (de_rw[1] == d_rs[RSEL_W-1]) && (de_rd == d_rs[RSEL_W-2:0]);
  assign hit_t = d_use_t && (de_rw[1] == d_rt[RSEL_W-1]) && (de_rd == d_rt[RSEL_W-2:0]);

  assign stall_lu = de_is_load && (de_rw != RW_NONE) && (hit_s || hit_t);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: multi-cycle execute stall, stop/halt, redirect and load-use bubbles.
// Outputs are combinational from the registered state/counter and the current hazard inputs.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int WAIT_W = 5,
  parameter int RSEL_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  pipeline_ctrl_if.slave    bus
);

  ctrl_state_t       state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;

  logic stall_lu;
  upd_t fd_d, de_d, ew_d;
  logic pc_en_d, halted_d;

  load_use_detect #(.RSEL_W(RSEL_W)) u_lu (
    .d_rs       (bus.d_rs),
    .d_rt       (bus.d_rt),
    .d_use_s    (bus.d_use_s),
    .d_use_t    (bus.d_use_t),
    .de_rw      (bus.de_rw),
    .de_rd      (bus.de_rd),
    .de_is_load (bus.de_is_load),
    .stall_lu   (stall_lu)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fd_d     = UPD_ADV;
    de_d     = UPD_ADV;
    ew_d     = UPD_ADV;
    pc_en_d  = 1'b1;
    halted_d = 1'b0;

    if (state_q == HALT) begin
      fd_d     = UPD_HOLD;
      de_d     = UPD_HOLD;
      ew_d     = UPD_HOLD;
      pc_en_d  = 1'b0;
      halted_d = 1'b1;
      if (bus.resume) state_d = RUN;
    end else if ((state_q == RUN && bus.de_wait_time != '0) ||
                 (state_q == WAIT && cnt_q != '0)) begin
      // E keeps executing; a bubble leaves toward W while F and D hold.
      fd_d    = UPD_HOLD;
      de_d    = UPD_HOLD;
      ew_d    = UPD_FLUSH;
      pc_en_d = 1'b0;
      state_d = WAIT;
      cnt_d   = (state_q == RUN) ? bus.de_wait_time - WAIT_W'(1) : cnt_q - WAIT_W'(1);
    end else begin
      // RUN with no wait, or the final WAIT cycle where the E instruction retires.
      state_d = RUN;
      if (bus.de_stop) begin
        fd_d    = UPD_FLUSH;
        de_d    = UPD_FLUSH;
        ew_d    = UPD_ADV;
        pc_en_d = 1'b0;
        state_d = HALT;
      end else if (bus.e_redirect) begin
        fd_d    = UPD_FLUSH;
        de_d    = UPD_FLUSH;
        ew_d    = UPD_ADV;
        pc_en_d = 1'b1;
      end else if (stall_lu) begin
        fd_d    = UPD_HOLD;
        de_d    = UPD_FLUSH;
        ew_d    = UPD_ADV;
        pc_en_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset forces every pipeline register to hold and the PC to stay put.
  assign bus.fd_update = rst ? UPD_HOLD : fd_d;
  assign bus.de_update = rst ? UPD_HOLD : de_d;
  assign bus.ew_update = rst ? UPD_HOLD : ew_d;
  assign bus.pc_en     = rst ? 1'b0 : pc_en_d;
  assign bus.halted    = rst ? 1'b0 : halted_d;
  assign bus.dbg_state = state_q;
  assign bus.dbg_cnt   = cnt_q;

endmodule
